id_ex_operand_stage: RTL

//  ID/EX pipeline register plus operand forwarding and load-use hazard detection for the 5-stage MIPS pipe.

---
 rtl/id_ex_operand_stage_if.sv | 49 ++++
 rtl/id_ex_operand_stage.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage_if
//   Decoded-instruction bus from the ID stage into the ID/EX operand stage.
//   ID drives every signal through the master modport, and the operand stage
//   samples them through the slave modport.
//
//   id_valid        ID holds a real instruction
//   id_rs_addr/rt   source register numbers
//   id_dst_addr     destination register (rd/rt/31 already selected)
//   id_rs/rt_data   register-file read data
//   id_imm          extended immediate
//   id_shamt        shift amount
//   id_alu_ctl      ALU operation code
//   id_sign         signed-compare select
//   id_branch_type  branch condition code
//   id_src1_shamt   operand 1 comes from shamt instead of rs
//   id_src2_imm     operand 2 comes from imm instead of rt
//   id_reg_write / id_mem_read / id_mem_write   write-back and memory controls
// -----------------------------------------------------------------------------
interface id_ex_operand_stage_if;
  logic        id_valid;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic [4:0]  id_dst_addr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_shamt;
  logic [4:0]  id_alu_ctl;
  logic        id_sign;
  logic [2:0]  id_branch_type;
  logic        id_src1_shamt;
  logic        id_src2_imm;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_dst_addr, id_rs_data,
           id_rt_data, id_imm, id_shamt, id_alu_ctl, id_sign, id_branch_type,
           id_src1_shamt, id_src2_imm, id_reg_write, id_mem_read, id_mem_write
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_dst_addr, id_rs_data,
           id_rt_data, id_imm, id_shamt, id_alu_ctl, id_sign, id_branch_type,
           id_src1_shamt, id_src2_imm, id_reg_write, id_mem_read, id_mem_write
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
//   ID/EX pipeline register for the 5-stage MIPS pipe, with operand
//   forwarding from EX/MEM and MEM/WB and load-use hazard detection.
//
//   clk, reset        rising-edge clock, synchronous active-high reset
//   id_bus            decoded instruction from ID (slave modport)
//   flush             squash the instruction entering EX
//   exmem_*           EX/MEM write-back info used for forwarding
//   memwb_*           MEM/WB write-back info used for forwarding
//   stall             hold PC and IF/ID this cycle (combinational)
//   ex_valid          EX holds a real instruction
//   alu_in1/alu_in2   forwarded, source-selected ALU operands
//   ex_store_data     forwarded rt value for stores
//   ex_alu_ctl, ex_sign, ex_branch_type        registered ALU/branch controls
//   ex_dst, ex_reg_write, ex_mem_read, ex_mem_write   registered EX/MEM controls
// -----------------------------------------------------------------------------
module id_ex_operand_stage (
  input  logic                        clk,
  input  logic                        reset,
  id_ex_operand_stage_if.slave        id_bus,
  input  logic                        flush,
  input  logic                        exmem_reg_write,
  input  logic [4:0]                  exmem_dst,
  input  logic [31:0]                 exmem_result,
  input  logic                        memwb_reg_write,
  input  logic [4:0]                  memwb_dst,
  input  logic [31:0]                 memwb_result,
  output logic                        stall,
  output logic                        ex_valid,
  output logic [31:0]                 alu_in1,
  output logic [31:0]                 alu_in2,
  output logic [31:0]                 ex_store_data,
  output logic [4:0]                  ex_alu_ctl,
  output logic                        ex_sign,
  output logic [2:0]                  ex_branch_type,
  output logic [4:0]                  ex_dst,
  output logic                        ex_reg_write,
  output logic                        ex_mem_read,
  output logic                        ex_mem_write
);

  // Branch code meaning "not a branch"; a bubble must never look like one.
  localparam logic [2:0] BRANCH_NONE = 3'b100;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  dst;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  alu_ctl;
    logic        sign;
    logic [2:0]  branch_type;
    logic        src1_shamt;
    logic        src2_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } ex_state_t;

  ex_state_t ex_q;
  ex_state_t load_d;
  ex_state_t bubble_d;

  // Load-use hazard: the load in EX cannot forward its data in time, so the
  // consumer in ID waits one cycle. A flush discards the consumer anyway.
  assign stall = ~flush & id_bus.id_valid & ex_q.valid & ex_q.mem_read &
                 (ex_q.dst != 5'd0) &
                 ((ex_q.dst == id_bus.id_rs_addr) | (ex_q.dst == id_bus.id_rt_addr));

  // NOTE: every field gets a value on every pass through always_comb,
  // otherwise the tool infers a latch to hold the unassigned bits.
  always_comb begin
    bubble_d             = '0;
    bubble_d.branch_type = BRANCH_NONE;

    load_d             = '0;
    load_d.valid       = id_bus.id_valid;
    load_d.rs_addr     = id_bus.id_rs_addr;
    load_d.rt_addr     = id_bus.id_rt_addr;
    load_d.dst         = id_bus.id_dst_addr;
    load_d.rs_data     = id_bus.id_rs_data;
    load_d.rt_data     = id_bus.id_rt_data;
    load_d.imm         = id_bus.id_imm;
    load_d.shamt       = id_bus.id_shamt;
    load_d.alu_ctl     = id_bus.id_alu_ctl;
    load_d.sign        = id_bus.id_sign;
    load_d.branch_type = id_bus.id_branch_type;
    load_d.src1_shamt  = id_bus.id_src1_shamt;
    load_d.src2_imm    = id_bus.id_src2_imm;
    load_d.reg_write   = id_bus.id_reg_write;
    load_d.mem_read    = id_bus.id_mem_read;
    load_d.mem_write   = id_bus.id_mem_write;
  end

  // Priority reset > flush > stall > load; the first three all insert a bubble.
  // NOTE: state is assigned with <= so every register samples pre-edge values;
  // a blocking = here would let later logic in the block see the new value.
  always_ff @(posedge clk) begin
    if (reset || flush || stall) begin
      ex_q <= bubble_d;
    end else begin
      ex_q <= load_d;
    end
  end

  // The youngest producer (EX/MEM) wins; register 0 is hard-wired to zero and
  // so is never a forwarding target.
  function automatic logic [31:0] forward_operand(
    input logic [4:0]  addr,
    input logic [31:0] reg_data,
    input logic        xm_write,
    input logic [4:0]  xm_dst,
    input logic [31:0] xm_result,
    input logic        mw_write,
    input logic [4:0]  mw_dst,
    input logic [31:0] mw_result
  );
    if (xm_write && (xm_dst != 5'd0) && (xm_dst == addr)) begin
      return xm_result;
    end else if (mw_write && (mw_dst != 5'd0) && (mw_dst == addr)) begin
      return mw_result;
    end else begin
      return reg_data;
    end
  endfunction

  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  assign fwd_rs = forward_operand(ex_q.rs_addr, ex_q.rs_data,
                                  exmem_reg_write, exmem_dst, exmem_result,
                                  memwb_reg_write, memwb_dst, memwb_result);
  assign fwd_rt = forward_operand(ex_q.rt_addr, ex_q.rt_data,
                                  exmem_reg_write, exmem_dst, exmem_result,
                                  memwb_reg_write, memwb_dst, memwb_result);

  assign alu_in1       = ex_q.src1_shamt ? {27'b0, ex_q.shamt} : fwd_rs;
  assign alu_in2       = ex_q.src2_imm ? ex_q.imm : fwd_rt;
  // Stores take rt as data even though imm feeds the address add.
  assign ex_store_data = fwd_rt;

  assign ex_valid       = ex_q.valid;
  assign ex_alu_ctl     = ex_q.alu_ctl;
  assign ex_sign        = ex_q.sign;
  assign ex_branch_type = ex_q.branch_type;
  assign ex_dst         = ex_q.dst;
  assign ex_reg_write   = ex_q.reg_write;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_mem_write   = ex_q.mem_write;

endmodule
